// File: rtl/nic_ctrl_pkg.sv
// Shared constants and state encoding for the NIC access sequencer.
// Optional timeout support is enabled with the NIC_TIMEOUT_EN macro.
package nic_ctrl_pkg;

  localparam logic [1:0] NIC_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  localparam int NIC_STAT_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT,
    ST_SCHK,
    ST_GAP,
    ST_DATA,
    ST_DONE
  } state_t;

  // Loads wait on the input channel, stores on the output channel.
  function automatic logic [1:0] stat_addr_for(input logic wr);
    return wr ? NIC_OUT_STAT : NIC_IN_STAT;
  endfunction

endpackage

// File: rtl/nic_wait_timer.sv
// Poll-gap down-counter plus an optional wait-timeout up-counter.
// The timeout counter exists only when NIC_TIMEOUT_EN is defined.
module nic_wait_timer
  import nic_ctrl_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_gap_load,
  input  logic i_gap_en,
  output logic o_gap_zero,
  input  logic i_wait_clr,
  input  logic i_wait_en,
  output logic o_wait_expired
);

  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [GAP_W-1:0] r_gap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap <= '0;
    end else if (i_gap_load) begin
      r_gap <= GAP_W'(POLL_GAP - 1);
    end else if (i_gap_en) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

  assign o_gap_zero = (r_gap == '0);

`ifdef NIC_TIMEOUT_EN
  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset || i_wait_clr) begin
      r_wait <= '0;
    end else if (i_wait_en) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Fires during the TIMEOUT-th wait cycle so the FSM leaves on that edge.
  assign o_wait_expired = (r_wait == WAIT_W'(TIMEOUT - 1));
`else
  logic [WAIT_W-1:0] w_unused_wait;
  assign w_unused_wait  = {WAIT_W{i_wait_clr ^ i_wait_en}};
  assign o_wait_expired = 1'b0;
`endif

endmodule

// File: rtl/nic_access_sequencer.sv
// Blocking, status-polled NIC register access sequencer between MEM and the NIC.
// Define NIC_TIMEOUT_EN to bound the channel-ready wait and enable timeout_err.
module nic_access_sequencer
  import nic_ctrl_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_nic_en,
  input  logic              mem_nic_wr,
  input  logic [1:0]        mem_nic_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] nic_dout,
  output logic              nic_en,
  output logic              nic_wr_en,
  output logic [1:0]        nic_addr,
  output logic [DATA_W-1:0] nic_din,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              stall,
  output logic              timeout_err
);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_nic_en, r_nic_wr;
  logic [1:0]        r_nic_addr;
  logic [DATA_W-1:0] r_nic_din, r_load_data;
  logic              r_wr, r_rd, r_timed;
  logic [1:0]        r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_nic_en_d, w_nic_wr_d;
  logic [1:0]        w_nic_addr_d;
  logic [DATA_W-1:0] w_nic_din_d;
  logic              w_lat_en, w_rd_set, w_tout, w_cap, w_ready;
  logic              w_gap_load, w_gap_en, w_gap_zero;
  logic              w_wait_clr, w_wait_en, w_wait_exp;

  nic_wait_timer #(
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_gap_load     (w_gap_load),
    .i_gap_en       (w_gap_en),
    .o_gap_zero     (w_gap_zero),
    .i_wait_clr     (w_wait_clr),
    .i_wait_en      (w_wait_en),
    .o_wait_expired (w_wait_exp)
  );

  // In-status reports ready as 1, out-status reports ready (not full) as 0.
  assign w_ready = r_wr ? ~nic_dout[NIC_STAT_BIT] : nic_dout[NIC_STAT_BIT];

  always_comb begin
    w_nxt        = r_state;
    w_nic_en_d   = 1'b0;
    w_nic_wr_d   = 1'b0;
    w_nic_addr_d = r_nic_addr;
    w_nic_din_d  = r_nic_din;
    w_lat_en     = 1'b0;
    w_rd_set     = 1'b0;
    w_tout       = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_en     = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_en    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (mem_nic_en) begin
          w_lat_en = 1'b1;
          if ((!mem_nic_wr && mem_nic_addr == NIC_IN_DATA) ||
              ( mem_nic_wr && mem_nic_addr == NIC_OUT_DATA)) begin
            w_nxt        = ST_STAT;
            w_nic_en_d   = 1'b1;
            w_nic_addr_d = stat_addr_for(mem_nic_wr);
            w_wait_clr   = 1'b1;
          end else if (!mem_nic_wr && mem_nic_addr[0]) begin
            w_nxt        = ST_DATA;
            w_nic_en_d   = 1'b1;
            w_nic_addr_d = mem_nic_addr;
            w_rd_set     = 1'b1;
          end else begin
            w_nxt = ST_DONE;
          end
        end
      end
      ST_STAT: begin
        w_wait_en = 1'b1;
        if (w_wait_exp) begin
          w_nxt  = ST_DONE;
          w_tout = 1'b1;
        end else begin
          w_nxt = ST_SCHK;
        end
      end
      ST_SCHK: begin
        w_wait_en = 1'b1;
        if (w_wait_exp) begin
          w_nxt  = ST_DONE;
          w_tout = 1'b1;
        end else if (w_ready) begin
          w_nxt        = ST_DATA;
          w_nic_en_d   = 1'b1;
          w_nic_wr_d   = r_wr;
          w_nic_addr_d = r_addr;
          w_nic_din_d  = r_data;
          w_rd_set     = ~r_wr;
        end else begin
          w_nxt      = ST_GAP;
          w_gap_load = 1'b1;
        end
      end
      ST_GAP: begin
        w_wait_en = 1'b1;
        if (w_wait_exp) begin
          w_nxt  = ST_DONE;
          w_tout = 1'b1;
        end else if (w_gap_zero) begin
          w_nxt        = ST_STAT;
          w_nic_en_d   = 1'b1;
          w_nic_addr_d = stat_addr_for(r_wr);
        end else begin
          w_gap_en = 1'b1;
        end
      end
      ST_DATA: w_nxt = ST_DONE;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Read data from the DATA-cycle strobe arrives during DONE.
  assign w_cap = (r_state == ST_DONE) && !r_wr && (r_rd || r_timed);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_nic_en    <= 1'b0;
      r_nic_wr    <= 1'b0;
      r_nic_addr  <= 2'b00;
      r_nic_din   <= '0;
      r_load_data <= '0;
      r_wr        <= 1'b0;
      r_addr      <= 2'b00;
      r_rd        <= 1'b0;
      r_timed     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_nic_en   <= w_nic_en_d;
      r_nic_wr   <= w_nic_wr_d;
      r_nic_addr <= w_nic_addr_d;
      r_nic_din  <= w_nic_din_d;
      if (w_lat_en) begin
        r_wr   <= mem_nic_wr;
        r_addr <= mem_nic_addr;
      end
      if (w_rd_set) begin
        r_rd <= 1'b1;
      end else if (w_lat_en) begin
        r_rd <= 1'b0;
      end
      if (w_lat_en) begin
        r_timed <= 1'b0;
      end else if (w_tout) begin
        r_timed <= 1'b1;
      end
      if (w_cap) begin
        r_load_data <= r_timed ? '0 : nic_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_lat_en) begin
      r_data <= mem_wr_data;
    end
  end

`ifdef NIC_TIMEOUT_EN
  logic r_tout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tout_err <= 1'b0;
    end else if (w_tout) begin
      r_tout_err <= 1'b1;
    end
  end

  assign timeout_err = r_tout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign nic_en    = r_nic_en;
  assign nic_wr_en = r_nic_wr;
  assign nic_addr  = r_nic_addr;
  assign nic_din   = r_nic_din;
  assign load_data = r_load_data;
  assign done      = (r_state == ST_DONE);
  assign stall     = mem_nic_en & ~done & ~reset;

endmodule

// File: tb/tb_nic_access_sequencer.sv
// Self-checking bench for nic_access_sequencer: directed plan cases plus random
// requests against a transaction-level latency/access model and a NIC responder.
module tb_nic_access_sequencer;
  import nic_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int P  = 4;
  localparam int TO = 16;
`ifdef NIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_nic_en, mem_nic_wr;
  logic [1:0]    mem_nic_addr;
  logic [DW-1:0] mem_wr_data, nic_dout;
  logic          nic_en, nic_wr_en, done, stall, timeout_err;
  logic [1:0]    nic_addr;
  logic [DW-1:0] nic_din, load_data;

  nic_access_sequencer #(.DATA_W(DW), .POLL_GAP(P), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_nic_en(mem_nic_en), .mem_nic_wr(mem_nic_wr),
    .mem_nic_addr(mem_nic_addr), .mem_wr_data(mem_wr_data), .nic_dout(nic_dout),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en), .nic_addr(nic_addr), .nic_din(nic_din),
    .load_data(load_data), .done(done), .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [1:0]    addr;
    logic [DW-1:0] din;
  } acc_t;

  acc_t          log_q[$];
  acc_t          exp_q[$];
  int            in_busy, out_busy;
  logic [DW-1:0] in_data_reg, sthi;
  logic [DW-1:0] cur_ld;
  logic          te_exp;
  int            n_asrt, n_fail;

  // NIC responder: registered read, data valid the cycle after the strobe.
  initial begin : nic_model
    logic          pend;
    logic [DW-1:0] resp;
    nic_dout = '0;
    resp     = '0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (nic_en === 1'b1) begin
        log_q.push_back('{nic_wr_en, nic_addr, nic_din});
        if (nic_wr_en !== 1'b1) begin
          pend = 1'b1;
          case (nic_addr)
            NIC_IN_STAT: begin
              resp = {sthi[DW-1:1], (in_busy == 0)};
              if (in_busy > 0) in_busy--;
            end
            NIC_OUT_STAT: begin
              resp = {sthi[DW-1:1], (out_busy != 0)};
              if (out_busy > 0) out_busy--;
            end
            default: resp = in_data_reg;
          endcase
        end
      end
      @(posedge clk);
      #1;
      if (pend) nic_dout = resp;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after a posedge+1; returns one cycle after done was seen.
  task automatic run_req(input logic wr, input logic [1:0] addr, input logic [DW-1:0] data,
                         input int k, input logic [DW-1:0] indata, input logic [DW-1:0] hi,
                         input bit keep, input int flush_at);
    int       lat, waits, n, stalls;
    bit       got_done, blocking, sread, b;
    logic [1:0] sa;
    logic [DW-1:0] exp_ld;
    blocking = (!wr && addr == NIC_IN_DATA) || (wr && addr == NIC_OUT_DATA);
    sread    = !wr && addr[0];
    sa       = wr ? NIC_OUT_STAT : NIC_IN_STAT;
    exp_q.delete();
    exp_ld = cur_ld;
    lat    = 2;
    if (blocking) begin
      waits = 2 + k * (P + 2);
      if (TO_EN && waits >= TO) begin
        lat = 2 + TO;
        for (int j = 0; j <= k; j++)
          if (j * (P + 2) < TO) exp_q.push_back('{1'b0, sa, '0});
        if (!wr) exp_ld = '0;
        te_exp = 1'b1;
      end else begin
        lat = 3 + waits;
        for (int j = 0; j <= k; j++) exp_q.push_back('{1'b0, sa, '0});
        exp_q.push_back('{wr, addr, data});
        if (!wr) exp_ld = indata;
      end
    end else if (sread) begin
      lat = 3;
      exp_q.push_back('{1'b0, addr, '0});
      b = (addr == NIC_IN_STAT) ? (k == 0) : (k != 0);
      exp_ld = {hi[DW-1:1], b};
    end
    in_busy     = k;
    out_busy    = k;
    in_data_reg = indata;
    sthi        = hi;
    log_q.delete();
    mem_nic_en   = 1'b1;
    mem_nic_wr   = wr;
    mem_nic_addr = addr;
    mem_wr_data  = data;
    n = 0; stalls = 0; got_done = 1'b0;
    while (!got_done && n < 300) begin
      @(negedge clk);
      n++;
      if (stall === 1'b1) stalls++;
      if (done === 1'b1) got_done = 1'b1;
      if (flush_at == n) mem_nic_en = 1'b0;
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("done_cycle", 64'(n), 64'(lat));
    if (flush_at == 0) chk("stall_cycles", 64'(stalls), 64'(lat - 1));
    @(posedge clk);
    #1;
    chk("done_pulse_width", 64'(done), 64'd0);
    chk("acc_count", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("acc_wr", 64'(log_q[i].wr), 64'(exp_q[i].wr));
      chk("acc_addr", 64'(log_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].wr) chk("acc_din", log_q[i].din, exp_q[i].din);
    end
    chk("load_data", load_data, exp_ld);
    chk("timeout_err", 64'(timeout_err), 64'(te_exp));
    cur_ld = exp_ld;
    if (!keep) mem_nic_en = 1'b0;
  endtask

  initial begin : main
    int nwr;
    logic w;
    logic [1:0] a;
    n_asrt = 0; n_fail = 0;
    cur_ld = '0; te_exp = 1'b0;
    in_busy = 0; out_busy = 0; in_data_reg = '0; sthi = '0;
    reset = 1'b1;
    mem_nic_en = 1'b1; mem_nic_wr = 1'b0; mem_nic_addr = NIC_IN_STAT; mem_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_nic_en", 64'(nic_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load_data", load_data, '0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_nic_en = 1'b0;
    @(posedge clk); #1;

    run_req(1'b0, NIC_IN_STAT, '0, 0, '0, '0, 1'b0, 0);
    chk("stat_read_value", load_data, 64'h1);
    run_req(1'b1, NIC_OUT_DATA, 64'hDEADBEEF, 0, '0, {$urandom, $urandom}, 1'b0, 0);
    run_req(1'b0, NIC_IN_DATA, {$urandom, $urandom}, 2, 64'hA5, '0, 1'b0, 0);
    chk("load_blocking_value", load_data, 64'hA5);
    run_req(1'b1, NIC_IN_STAT, {$urandom, $urandom}, 0, '0, '0, 1'b0, 0);

    // Reset while waiting in the poll gap of a stalled store.
    @(posedge clk); #1;
    log_q.delete();
    out_busy = 1000;
    mem_nic_en = 1'b1; mem_nic_wr = 1'b1; mem_nic_addr = NIC_OUT_DATA; mem_wr_data = 64'h1234;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("midrst_nic_en", 64'(nic_en), 64'd0);
    chk("midrst_nic_wr_en", 64'(nic_wr_en), 64'd0);
    chk("midrst_nic_addr", 64'(nic_addr), 64'd0);
    chk("midrst_nic_din", nic_din, '0);
    chk("midrst_load_data", load_data, '0);
    chk("midrst_done", 64'(done), 64'd0);
    reset = 1'b0; mem_nic_en = 1'b0; out_busy = 0;
    cur_ld = '0; te_exp = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    nwr = 0;
    foreach (log_q[i]) if (log_q[i].wr) nwr++;
    chk("midrst_no_write", 64'(nwr), 64'd0);
    run_req(1'b0, NIC_IN_DATA, '0, 0, {$urandom, $urandom}, '0, 1'b0, 0);

`ifdef NIC_TIMEOUT_EN
    run_req(1'b1, NIC_OUT_DATA, 64'hBAD, 1000, '0, '0, 1'b0, 0);
    chk("timeout_flag", 64'(timeout_err), 64'd1);
    run_req(1'b0, NIC_IN_DATA, '0, 1, 64'h77, '0, 1'b0, 0);
    run_req(1'b0, NIC_IN_DATA, '0, 1000, 64'h99, '0, 1'b0, 0);
`endif

    // Back-to-back store then load, then a flushed store.
    run_req(1'b1, NIC_OUT_DATA, 64'hCAFE_0001, 1, '0, '0, 1'b1, 0);
    run_req(1'b0, NIC_IN_DATA, '0, 0, 64'h5A5A, '0, 1'b0, 0);
    run_req(1'b1, NIC_OUT_DATA, 64'hF1F1, 1, '0, '0, 1'b0, 2);

    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      if (!w && a == NIC_OUT_DATA) a = NIC_IN_DATA;
      run_req(w, a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
              {$urandom, $urandom}, {$urandom, $urandom},
              (t != 39) && ($urandom_range(0, 1) == 1), 0);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
